// File: rtl/xrv_imem_ld.sv
// rtl/xrv_imem_ld.sv - instruction memory with one-cycle fetch and byte-serial loader
module xrv_imem_ld #(
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  input  logic        ld_start,
  input  logic [31:0] ld_len,
  input  logic [7:0]  ld_byte,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic        cpu_hold
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_LOAD = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;
  localparam logic [32:0] MAX_LEN = 33'd4 << AW;

  logic [1:0]    state;
  logic [31:0]   rem;
  logic [AW-1:0] wptr;
  logic [1:0]    bidx;
  logic [31:0]   asm_q;
  logic [31:0]   mem [0:(1<<AW)-1];

  logic          take;
  logic          flush;
  logic [31:0]   asm_nxt;
  logic          unused_addr;

  assign take    = (state == ST_LOAD) && ld_valid;
  // upper lanes of asm_q are still zero, so OR-ing the new byte in is enough
  assign asm_nxt = asm_q | ({24'd0, ld_byte} << {bidx, 3'b000});
  assign flush   = take && ((bidx == 2'd3) || (rem == 32'd1));

  assign ld_ready = (state == ST_LOAD);
  assign ld_busy  = (state == ST_LOAD);
  assign ld_done  = (state == ST_DONE);
  assign cpu_hold = (state != ST_IDLE);

  assign unused_addr = ^{i_addr[31:AW+2], i_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst && flush)
      mem[wptr] <= asm_nxt;
  end

  // read-before-write: a same-edge write to the fetched word returns old data
  always_ff @(posedge clk) begin
    if (rst)
      i_data <= 32'd0;
    else
      i_data <= mem[i_addr[AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rem    <= 32'd0;
      wptr   <= '0;
      bidx   <= 2'd0;
      asm_q  <= 32'd0;
      ld_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_start) begin
            if ({1'b0, ld_len} > MAX_LEN) begin
              ld_err <= 1'b1;
            end else begin
              ld_err <= 1'b0;
              if (ld_len == 32'd0) begin
                state <= ST_DONE;
              end else begin
                rem   <= ld_len;
                wptr  <= '0;
                bidx  <= 2'd0;
                asm_q <= 32'd0;
                state <= ST_LOAD;
              end
            end
          end
        end
        ST_LOAD: begin
          if (take) begin
            rem  <= rem - 32'd1;
            bidx <= bidx + 2'd1;
            if (flush) begin
              asm_q <= 32'd0;
              wptr  <= wptr + 1'b1;
            end else begin
              asm_q <= asm_nxt;
            end
            if (rem == 32'd1)
              state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xrv_imem_ld.sv
// tb/tb_xrv_imem_ld.sv - scoreboard bench for xrv_imem_ld
module tb_xrv_imem_ld;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        ld_start;
  logic [31:0] ld_len;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_ready, ld_busy, ld_done, ld_err, cpu_hold;

  xrv_imem_ld #(.AW(12)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_data(i_data),
    .ld_start(ld_start), .ld_len(ld_len), .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  // expectations describe the outputs right after the next rising edge
  logic [31:0] fq[$];
  string       fn[$];
  logic [4:0]  sq[$];
  string       sn[$];
  logic        fr = 1'b0;
  logic        sr = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) begin
    logic        lf, ls;
    logic [31:0] fe;
    logic [4:0]  se, sa;
    string       nm;
    lf = fr;
    ls = sr;
    #1;
    if (lf) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fetch_queue: i_data=%h with no expected value", i_data);
      end else begin
        fe = fq.pop_front();
        nm = fn.pop_front();
        if (i_data !== fe) begin
          errors++;
          $display("FAIL %s: i_data=%h expected %h", nm, i_data, fe);
        end
      end
    end
    if (ls) begin
      checks++;
      sa = {cpu_hold, ld_busy, ld_ready, ld_done, ld_err};
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL status_queue: status=%b with no expected value", sa);
      end else begin
        se = sq.pop_front();
        nm = sn.pop_front();
        if (sa !== se) begin
          errors++;
          $display("FAIL %s: {hold,busy,ready,done,err}=%b expected %b", nm, sa, se);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    fr = 1'b0;
    sr = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] e, input string n);
    i_addr = a;
    fr = 1'b1;
    fq.push_back(e);
    fn.push_back(n);
  endtask

  task automatic expst(input logic [4:0] e, input string n);
    sr = 1'b1;
    sq.push_back(e);
    sn.push_back(n);
  endtask

  task automatic start(input logic [31:0] len, input logic [4:0] e, input string n);
    ld_start = 1'b1;
    ld_len = len;
    expst(e, n);
    step();
  endtask

  task automatic send(input logic [7:0] b, input logic [4:0] e);
    ld_valid = 1'b1;
    ld_byte = b;
    expst(e, "load_status");
    step();
  endtask

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_LOAD = 5'b11100;
  localparam logic [4:0] S_DONE = 5'b10010;
  localparam logic [4:0] S_ERR  = 5'b00001;

  initial begin
    logic [7:0] prog [8];
    rst = 1'b1; i_addr = 32'd0; ld_start = 1'b0; ld_len = 32'd0;
    ld_byte = 8'd0; ld_valid = 1'b0;
    @(negedge clk);
    fetch(32'h0, 32'h0, "reset_idata");
    expst(S_IDLE, "reset_status");
    step();
    rst = 1'b0;
    step();

    // 8-byte program
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    start(32'd8, S_LOAD, "start_busy");
    for (int i = 0; i < 8; i++) send(prog[i], (i == 7) ? S_DONE : S_LOAD);
    fetch(32'h4, 32'h00100093, "final_word_after_done");
    expst(S_IDLE, "hold_falls");
    step();
    fetch(32'h0, 32'h00000013, "prog_word0");
    step();

    // 6 bytes with ld_valid gaps
    start(32'd6, S_LOAD, "start_gap_load");
    for (int i = 0; i < 6; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        expst(S_LOAD, "gap_ready_high");
        step();
      end
      send(8'h11 + 8'(i), (i == 5) ? S_DONE : S_LOAD);
    end
    expst(S_IDLE, "gap_ready_low");
    step();

    // back-to-back fetches incl. unaligned and aliased addresses
    fetch(32'h0000, 32'h14131211, "fetch_0x0");    step();
    fetch(32'h0004, 32'h00001615, "fetch_0x4");    step();
    fetch(32'h0006, 32'h00001615, "fetch_0x6");    step();
    fetch(32'h4000, 32'h14131211, "fetch_alias");  step();

    // read/write collision on word 1
    start(32'd8, S_LOAD, "start_collision");
    for (int i = 0; i < 7; i++) send(8'hA0 + 8'(i), S_LOAD);
    fetch(32'h4, 32'h00001615, "rw_collision_old");
    send(8'hA7, S_DONE);
    fetch(32'h4, 32'hA7A6A5A4, "rw_collision_new");
    expst(S_IDLE, "collision_idle");
    step();

    // oversize start rejected, then cleared by an in-range start
    start(32'h4001, S_ERR, "oversize_err");
    fetch(32'h0, 32'hA3A2A1A0, "err_mem_unchanged");
    expst(S_ERR, "err_sticky");
    step();
    start(32'd4, S_LOAD, "err_cleared");
    for (int i = 0; i < 4; i++) send(8'h01 + 8'(i), (i == 3) ? S_DONE : S_LOAD);
    expst(S_IDLE, "len4_idle");
    step();
    fetch(32'h0, 32'h04030201, "len4_word0");
    step();

    // zero-length load
    start(32'd0, S_DONE, "len0_done");
    expst(S_IDLE, "len0_idle");
    step();

    // reset in the middle of a 12-byte load
    start(32'd12, S_LOAD, "start_rst_load");
    for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), S_LOAD);
    rst = 1'b1;
    ld_valid = 1'b1;
    ld_byte = 8'h26;
    ld_start = 1'b1;
    ld_len = 32'd4;
    expst(S_IDLE, "rst_midload");
    step();
    rst = 1'b0;
    expst(S_IDLE, "rst_stays_idle");
    step();
    fetch(32'h0, 32'h24232221, "rst_word0_kept");
    step();
    fetch(32'h4, 32'hA7A6A5A4, "rst_word1_prior");
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
